// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 event to ASCII translator with modifier tracking and a character FIFO.
// Optional KBD_ASCII_LED_EN adds led_o (registered modifier copy) and a sticky overflow_o.
module kbd_ascii_decoder #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   read_valid_i,
    input  logic [15:0]            read_data_i,
    output logic                   read_enable_o,
    input  logic                   char_read_i,
    output logic [7:0]             char_o,
    output logic                   char_valid_o,
    output logic [$clog2(DEPTH):0] char_count_o,
    output logic [2:0]             mods_o,
    output logic                   dbg_state_o
`ifdef KBD_ASCII_LED_EN
    ,
    output logic [2:0]             led_o,
    output logic                   overflow_o
`endif
);
    // Handshake: an upstream event is consumed on any cycle where read_enable_o && read_valid_i.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, DECODE = 1'b1} state_t;

    state_t        state;
    logic [9:0]    ev_q;
    logic          shift_l, shift_r, ctrl_l, ctrl_r, caps;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          ev_ext, ev_brk;
    logic [7:0]    ev_sc;
    logic [15:0]   entry;
    logic          is_letter, is_mod, use_shifted, shift_on, ctrl_on;
    logic          xlat_valid;
    logic [7:0]    xlat_char;
    logic          push, pop;
    logic          unused_bits;

    // Returns {shifted, unshifted} for a US layout; 0 marks an untranslated code.
    function automatic logic [15:0] lookup(input logic [6:0] code);
        case (code)
            7'h0D: lookup = {8'h09, 8'h09};
            7'h0E: lookup = {8'h7E, 8'h60};
            7'h15: lookup = {8'h51, 8'h71};
            7'h16: lookup = {8'h21, 8'h31};
            7'h1A: lookup = {8'h5A, 8'h7A};
            7'h1B: lookup = {8'h53, 8'h73};
            7'h1C: lookup = {8'h41, 8'h61};
            7'h1D: lookup = {8'h57, 8'h77};
            7'h1E: lookup = {8'h40, 8'h32};
            7'h21: lookup = {8'h43, 8'h63};
            7'h22: lookup = {8'h58, 8'h78};
            7'h23: lookup = {8'h44, 8'h64};
            7'h24: lookup = {8'h45, 8'h65};
            7'h25: lookup = {8'h24, 8'h34};
            7'h26: lookup = {8'h23, 8'h33};
            7'h29: lookup = {8'h20, 8'h20};
            7'h2A: lookup = {8'h56, 8'h76};
            7'h2B: lookup = {8'h46, 8'h66};
            7'h2C: lookup = {8'h54, 8'h74};
            7'h2D: lookup = {8'h52, 8'h72};
            7'h2E: lookup = {8'h25, 8'h35};
            7'h31: lookup = {8'h4E, 8'h6E};
            7'h32: lookup = {8'h42, 8'h62};
            7'h33: lookup = {8'h48, 8'h68};
            7'h34: lookup = {8'h47, 8'h67};
            7'h35: lookup = {8'h59, 8'h79};
            7'h36: lookup = {8'h5E, 8'h36};
            7'h3A: lookup = {8'h4D, 8'h6D};
            7'h3B: lookup = {8'h4A, 8'h6A};
            7'h3C: lookup = {8'h55, 8'h75};
            7'h3D: lookup = {8'h26, 8'h37};
            7'h3E: lookup = {8'h2A, 8'h38};
            7'h41: lookup = {8'h3C, 8'h2C};
            7'h42: lookup = {8'h4B, 8'h6B};
            7'h43: lookup = {8'h49, 8'h69};
            7'h44: lookup = {8'h4F, 8'h6F};
            7'h45: lookup = {8'h29, 8'h30};
            7'h46: lookup = {8'h28, 8'h39};
            7'h49: lookup = {8'h3E, 8'h2E};
            7'h4A: lookup = {8'h3F, 8'h2F};
            7'h4B: lookup = {8'h4C, 8'h6C};
            7'h4C: lookup = {8'h3A, 8'h3B};
            7'h4D: lookup = {8'h50, 8'h70};
            7'h4E: lookup = {8'h5F, 8'h2D};
            7'h52: lookup = {8'h22, 8'h27};
            7'h54: lookup = {8'h7B, 8'h5B};
            7'h55: lookup = {8'h2B, 8'h3D};
            7'h5A: lookup = {8'h0D, 8'h0D};
            7'h5B: lookup = {8'h7D, 8'h5D};
            7'h5D: lookup = {8'h7C, 8'h5C};
            7'h66: lookup = {8'h08, 8'h08};
            7'h76: lookup = {8'h1B, 8'h1B};
            default: lookup = 16'h0000;
        endcase
    endfunction

    assign unused_bits   = ^read_data_i[15:10];
    assign ev_ext        = ev_q[9];
    assign ev_brk        = ev_q[8];
    assign ev_sc         = ev_q[7:0];
    assign shift_on      = shift_l | shift_r;
    assign ctrl_on       = ctrl_l | ctrl_r;
    assign mods_o        = {caps, ctrl_on, shift_on};
    assign dbg_state_o   = (state == DECODE);
    assign read_enable_o = !reset_i && (state == IDLE) && read_valid_i && (count < FULL);

    always_comb begin
        entry       = lookup(ev_sc[6:0]);
        is_letter   = (entry[7:0] >= 8'h61) && (entry[7:0] <= 8'h7A);
        is_mod      = ev_ext ? (ev_sc == 8'h14) : (ev_sc inside {8'h12, 8'h14, 8'h58, 8'h59});
        use_shifted = is_letter ? (shift_on ^ caps) : shift_on;
        xlat_valid  = 1'b0;
        xlat_char   = 8'h00;
        if (!ev_brk && !is_mod) begin
            if (ev_ext) begin
                if (ev_sc == 8'h4A) begin
                    xlat_valid = 1'b1;
                    xlat_char  = 8'h2F;
                end else if (ev_sc == 8'h5A) begin
                    xlat_valid = 1'b1;
                    xlat_char  = 8'h0D;
                end
            end else if (!ev_sc[7] && (entry[7:0] != 8'h00)) begin
                // Ctrl only yields control codes for letters; other keys are swallowed.
                if (ctrl_on) begin
                    if (is_letter) begin
                        xlat_valid = 1'b1;
                        xlat_char  = entry[7:0] & 8'h1F;
                    end
                end else begin
                    xlat_valid = 1'b1;
                    xlat_char  = use_shifted ? entry[15:8] : entry[7:0];
                end
            end
        end
    end

    assign push = (state == DECODE) && xlat_valid;
    assign pop  = char_read_i && (count != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            ev_q    <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            ctrl_l  <= 1'b0;
            ctrl_r  <= 1'b0;
            caps    <= 1'b0;
`ifdef KBD_ASCII_LED_EN
            led_o      <= '0;
            overflow_o <= 1'b0;
`endif
        end else begin
`ifdef KBD_ASCII_LED_EN
            led_o <= mods_o;
            if ((state == DECODE) && !ev_brk && !is_mod && !xlat_valid && ctrl_on)
                overflow_o <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (read_enable_o) begin
                        ev_q  <= read_data_i[9:0];
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    if (ev_ext) begin
                        if (ev_sc == 8'h14) ctrl_r <= !ev_brk;
                    end else begin
                        case (ev_sc)
                            8'h12: shift_l <= !ev_brk;
                            8'h59: shift_r <= !ev_brk;
                            8'h14: ctrl_l  <= !ev_brk;
                            8'h58: if (!ev_brk) caps <= !caps;
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) mem[wr_ptr] <= xlat_char;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign char_valid_o = (count != '0);
    assign char_o       = char_valid_o ? mem[rd_ptr] : 8'h00;
    assign char_count_o = count;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Bench for kbd_ascii_decoder (DEPTH=4): directed scenarios plus random events
// against a per-cycle reference of FIFO contents, modifiers and handshake.
module tb_kbd_ascii_decoder;
  localparam int DEPTH = 4;

  logic        clk_i;
  logic        reset_i;
  logic        read_valid_i;
  logic [15:0] read_data_i;
  logic        read_enable_o;
  logic        char_read_i;
  logic [7:0]  char_o;
  logic        char_valid_o;
  logic [2:0]  char_count_o;
  logic [2:0]  mods_o;
  logic        dbg_state_o;

  kbd_ascii_decoder #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .read_valid_i (read_valid_i),
    .read_data_i  (read_data_i),
    .read_enable_o(read_enable_o),
    .char_read_i  (char_read_i),
    .char_o       (char_o),
    .char_valid_o (char_valid_o),
    .char_count_o (char_count_o),
    .mods_o       (mods_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  tbl_u [256];
  logic [7:0]  tbl_s [256];
  logic        m_shl, m_shr, m_ctl, m_ctr, m_caps;
  logic        model_live = 1'b0;
  logic        p1 = 1'b0, p2 = 1'b0;
  logic [15:0] p1_ev, p2_ev;
  logic        exp_re;
  logic        last_accept = 1'b0;
  int          accept_cnt = 0;
  logic        prod_done;
  logic [7:0]  pool [16] = '{8'h1C, 8'h16, 8'h12, 8'h59, 8'h14, 8'h58, 8'h29, 8'h5A,
                             8'h66, 8'h0D, 8'h76, 8'h4A, 8'h21, 8'h52, 8'h35, 8'h5D};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tbl_init();
    string lets;
    logic [7:0] pcodes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h0E,
                                8'h41, 8'h49, 8'h4A};
    logic [7:0] uchr [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h30, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h60,
                              8'h2C, 8'h2E, 8'h2F};
    logic [7:0] schr [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
                              8'h29, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h7E,
                              8'h3C, 8'h3E, 8'h3F};
    logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    for (int i = 0; i < 256; i++) begin
      tbl_u[i] = 8'h00;
      tbl_s[i] = 8'h00;
    end
    lets = "abcdefghijklmnopqrstuvwxyz";
    for (int i = 0; i < 26; i++) begin
      tbl_u[lcodes[i]] = lets[i];
      tbl_s[lcodes[i]] = lets[i] - 8'd32;
    end
    for (int i = 0; i < 21; i++) begin
      tbl_u[pcodes[i]] = uchr[i];
      tbl_s[pcodes[i]] = schr[i];
    end
    tbl_u[8'h29] = 8'h20; tbl_s[8'h29] = 8'h20;
    tbl_u[8'h5A] = 8'h0D; tbl_s[8'h5A] = 8'h0D;
    tbl_u[8'h66] = 8'h08; tbl_s[8'h66] = 8'h08;
    tbl_u[8'h0D] = 8'h09; tbl_s[8'h0D] = 8'h09;
    tbl_u[8'h76] = 8'h1B; tbl_s[8'h76] = 8'h1B;
  endtask

  task automatic model_clear();
    exp_q.delete();
    {m_shl, m_shr, m_ctl, m_ctr, m_caps} = '0;
  endtask

  // Effect of one accepted event on modifiers and the character stream.
  task automatic model_apply(input logic [15:0] ev);
    logic ext, brk, letter, shift, ctrl, sel;
    logic [7:0] sc, u;
    ext = ev[9];
    brk = ev[8];
    sc  = ev[7:0];
    if (!ext && sc == 8'h12) begin m_shl = !brk; return; end
    if (!ext && sc == 8'h59) begin m_shr = !brk; return; end
    if (!ext && sc == 8'h14) begin m_ctl = !brk; return; end
    if ( ext && sc == 8'h14) begin m_ctr = !brk; return; end
    if (!ext && sc == 8'h58) begin if (!brk) m_caps = !m_caps; return; end
    if (brk) return;
    if (ext) begin
      if (sc == 8'h4A) exp_q.push_back(8'h2F);
      else if (sc == 8'h5A) exp_q.push_back(8'h0D);
      return;
    end
    if (sc >= 8'h80) return;
    u = tbl_u[sc];
    if (u == 8'h00) return;
    letter = (u >= "a") && (u <= "z");
    shift  = m_shl || m_shr;
    ctrl   = m_ctl || m_ctr;
    if (ctrl) begin
      if (letter) exp_q.push_back(u & 8'h1F);
      return;
    end
    sel = letter ? (shift ^ m_caps) : shift;
    exp_q.push_back(sel ? tbl_s[sc] : u);
  endtask

  // Per-cycle scoreboard; an accepted event becomes visible two cycles later.
  always @(negedge clk_i) begin
    if (model_live) begin
      if (p2) model_apply(p2_ev);
      exp_re = !reset_i && read_valid_i && !p1 && (exp_q.size() < DEPTH);
      check_eq("read_enable", read_enable_o, exp_re);
      check_eq("fsm_decode", dbg_state_o, p1);
      check_eq("char_count", char_count_o, exp_q.size());
      check_eq("char_valid", char_valid_o, exp_q.size() != 0);
      check_eq("char_o", char_o, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      check_eq("mods", mods_o, {m_caps, m_ctl | m_ctr, m_shl | m_shr});
      if (char_read_i && exp_q.size() != 0) void'(exp_q.pop_front());
      p2 = p1;
      p2_ev = p1_ev;
      p1 = exp_re;
      p1_ev = read_data_i;
      if (exp_re) accept_cnt++;
      last_accept = exp_re;
    end else begin
      check_eq("read_enable_in_reset", read_enable_o, 1'b0);
      last_accept = 1'b0;
    end
    if (reset_i) begin
      model_clear();
      p1 = 1'b0;
      p2 = 1'b0;
      last_accept = 1'b0;
      model_live = 1'b1;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_event(input logic [15:0] ev);
    read_valid_i = 1'b1;
    read_data_i  = ev;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i);
      if (last_accept) begin
        #1;
        read_valid_i = 1'b0;
        return;
      end
    end
    check_eq("accept_timeout", 1'b0, 1'b1);
    #1;
    read_valid_i = 1'b0;
  endtask

  task automatic read_char(input string tag, input logic [7:0] exp);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_i);
      found = char_valid_o;
    end
    check_eq({tag, "_present"}, found, 1'b1);
    check_eq(tag, char_o, exp);
    @(posedge clk_i);
    #1 char_read_i = 1'b1;
    @(posedge clk_i);
    #1 char_read_i = 1'b0;
  endtask

  task automatic check_mods(input string tag, input logic [2:0] exp);
    @(negedge clk_i);
    check_eq(tag, mods_o, exp);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] rand_ev();
    logic [7:0] sc;
    logic ext, brk;
    logic [5:0] hi;
    sc  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
    ext = ($urandom_range(0, 5) == 0);
    brk = ($urandom_range(0, 2) == 0);
    hi  = 6'($urandom);
    return {hi, ext, brk, sc};
  endfunction

  initial begin
    logic found;
    tbl_init();
    reset_i      = 1'b1;
    read_valid_i = 1'b1;
    read_data_i  = 16'h001C;
    char_read_i  = 1'b0;
    prod_done    = 1'b0;

    // reset held with a valid upstream event
    repeat (5) @(posedge clk_i);
    #1 reset_i = 1'b0;
    read_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_count", char_count_o, 3'd0);
    check_eq("rst_mods", mods_o, 3'b000);
    check_eq("rst_char", char_o, 8'h00);
    tick(1);

    // plain key: char appears two cycles after acceptance, break adds nothing
    send_event(16'h001C);
    @(negedge clk_i);
    check_eq("lat_n1_empty", char_valid_o, 1'b0);
    @(negedge clk_i);
    check_eq("lat_n2_valid", char_valid_o, 1'b1);
    check_eq("lat_n2_char", char_o, 8'h61);
    tick(1);
    send_event(16'h011C);
    tick(4);
    check_eq("break_no_char", char_count_o, 3'd1);
    read_char("plain_a", 8'h61);

    // shift
    send_event(16'h0012);
    tick(1);
    check_mods("shift_on", 3'b001);
    send_event(16'h001C);
    send_event(16'h0016);
    send_event(16'h0112);
    tick(1);
    check_mods("shift_off", 3'b000);
    send_event(16'h0016);
    read_char("shift_A", 8'h41);
    read_char("shift_bang", 8'h21);
    read_char("unshift_1", 8'h31);

    // caps lock
    send_event(16'h0058);
    send_event(16'h0158);
    tick(1);
    check_mods("caps_on", 3'b100);
    send_event(16'h001C);
    send_event(16'h0016);
    send_event(16'h0012);
    send_event(16'h001C);
    read_char("caps_A", 8'h41);
    read_char("caps_1", 8'h31);
    read_char("caps_shift_a", 8'h61);
    send_event(16'h0112);
    send_event(16'h0058);
    tick(1);
    check_mods("caps_off", 3'b000);

    // right ctrl and extended codes
    send_event(16'h0214);
    tick(1);
    check_mods("ctrl_on", 3'b010);
    send_event(16'h0021);
    send_event(16'h0314);
    tick(1);
    check_mods("ctrl_off", 3'b000);
    send_event(16'h024A);
    send_event(16'h0276);
    read_char("ctrl_c", 8'h03);
    read_char("ext_slash", 8'h2F);
    tick(4);
    check_eq("ext_esc_dropped", char_count_o, 3'd0);

    // backpressure with a full FIFO, then reset while decoding
    accept_cnt   = 0;
    read_data_i  = 16'h001C;
    read_valid_i = 1'b1;
    tick(20);
    check_eq("bp_accepts", accept_cnt, 4);
    @(negedge clk_i);
    check_eq("bp_count", char_count_o, 3'd4);
    check_eq("bp_stalled", read_enable_o, 1'b0);
    @(posedge clk_i);
    #1 char_read_i = 1'b1;
    tick(1);
    char_read_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(posedge clk_i);
      found = last_accept;
    end
    check_eq("bp_resume", found, 1'b1);
    check_eq("bp_accepts5", accept_cnt, 5);
    #1 reset_i = 1'b1;
    tick(1);
    reset_i      = 1'b0;
    read_valid_i = 1'b0;
    tick(2);
    @(negedge clk_i);
    check_eq("rst_drop_count", char_count_o, 3'd0);
    check_eq("rst_drop_valid", char_valid_o, 1'b0);
    tick(1);

    // random traffic with a random consumer
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          tick($urandom_range(0, 2));
          send_event(rand_ev());
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          char_read_i = ($urandom_range(0, 2) != 0);
          tick(1);
        end
        char_read_i = 1'b0;
      end
    join
    char_read_i = 1'b1;
    tick(12);
    char_read_i = 1'b0;
    @(negedge clk_i);
    check_eq("final_drained", char_count_o, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_ascii_decoder.md
Name: kbd_ascii_decoder

Overview:
- Downstream consumer of the keyboard controller's event queue.
- Pops scancode events, tracks modifier state (shift, ctrl, caps lock), and translates PS/2 set-2 make codes to 8-bit ASCII.
- Buffers the characters in an internal FIFO that the CPU-side peripheral reads.
- Applies backpressure to the keyboard controller when its FIFO is full.

Parameters:
- DEPTH, 16: character FIFO entries; must be a power of two, ≥2.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- read_valid_i  in  1  upstream event queue non-empty; read_data_i holds head
- read_data_i  in  16  kbd event: [9] extended (E0 prefix), [8] break (F0 prefix), [7:0] set-2 scancode, [15:10] ignored
- read_enable_o  out  1  pop strobe to upstream; head consumed on any cycle with read_enable_o & read_valid_i
- char_read_i  in  1  pop strobe from consumer
- char_o  out  8  FIFO head character (valid when char_valid_o)
- char_valid_o  out  1  FIFO non-empty
- char_count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- mods_o  out  3  {caps_lock, ctrl, shift}

Behaviour:
- Reset (sync, highest priority, mid-operation included):
  - FSM → IDLE; FIFO emptied; all modifiers cleared.
  - read_enable_o=0, char_valid_o=0, char_count_o=0, mods_o=0, char_o=0.
  - An event latched before reset is discarded.
- FSM IDLE:
  - If read_valid_i && char_count_o<DEPTH: drive read_enable_o=1 combinationally that cycle, latch read_data_i into the event register, go to DECODE.
  - Otherwise read_enable_o=0 and stay in IDLE.
- FSM DECODE: read_enable_o=0; apply the rules below; always return to IDLE.
  - Throughput: one event per 2 cycles.
- Room check in IDLE guarantees the DECODE push never overflows (DECODE is the only pusher).
- Latency: event accepted in cycle N; pushed char visible on char_o/char_valid_o in cycle N+2 when the FIFO was empty.
- Modifier rules (make sets, break clears):
  - shift: 0x12 (left) or 0x59 (right); tracked as two separate bits, shift = OR of the two.
  - ctrl: 0x14 (left) or E0 0x14 (right); tracked as two separate bits, ctrl = OR of the two.
  - caps lock: 0x58 make toggles; break ignored; auto-repeat makes toggle each time.
- Non-modifier break events: no action.
- Translation of non-extended make codes:
  - 128-entry unshifted/shifted lookup on scancode[6:0]; scancode[7]=1 → drop.
  - US layout: digits and punctuation; space 0x29→0x20, enter 0x5A→0x0D, backspace 0x66→0x08, tab 0x0D→0x09, esc 0x76→0x1B.
  - Letters select the shifted table when shift XOR caps_lock; non-letters select it on shift only.
  - ctrl active with a letter: output = unshifted code & 0x1F.
  - ctrl active with a non-letter: drop.
  - Table entry 0x00 → drop; no push.
- Extended make codes:
  - E0 0x4A → '/' (0x2F); E0 0x5A → 0x0D.
  - All other extended codes → drop.
- FIFO:
  - Circular buffer, read/write pointers wrap mod DEPTH.
  - char_read_i while empty: ignored.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - char_o is the registered head; undefined-free (0x00) when empty.

Optional Feature:
- Macro: KBD_ASCII_LED_EN.
- Defined:
  - Adds output port led_o (3 bits) = {caps_lock, ctrl, shift}, registered, reset 0.
  - Adds sticky output overflow_o, set when an event is dropped by translation while ctrl is active; cleared by reset only.
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- Reset: hold reset_i 5 cycles with read_valid_i=1 → read_enable_o=0 throughout; char_count_o=0, mods_o=0 after release.
- Plain key: event 0x001C, then 0x011C → exactly one char 0x61 appears 2 cycles after acceptance; char_count_o=1; break adds nothing.
- Shift: 0x0012, 0x001C, 0x0016, 0x0112, 0x0016 → chars 0x41, 0x21, 0x31; mods_o goes 001 then 000.
- Caps lock: 0x0058, 0x0158, 0x001C, 0x0016, 0x0012, 0x001C → 0x41, 0x31, 0x61; mods_o[2]=1; second 0x0058 clears it.
- Ctrl and extended: 0x0214, 0x0021, 0x0314, 0x024A, 0x0276 → 0x03, 0x2F; E0 0x76 dropped; ctrl bit clears on 0x0314.
- Backpressure (DEPTH=4): six 'a' make events, char_read_i=0 → 4 accepted, read_enable_o stays 0, char_count_o=4. Pulse char_read_i once → 5th event accepted within 2 cycles. Reset during DECODE → latched event not pushed.
